// File: rtl/sync_fifo_ctrl_if.sv
// Bus interface for sync_fifo_ctrl.
// Groups the write/read request side and the status/data return side.
//   master : drives data_bus_in, write_ins, read_ins, flush, clear_flags
//            and observes data and status.
//   slave  : the FIFO side (the reverse of master).
interface sync_fifo_ctrl_if #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_bus_in;
  logic             write_ins;
  logic             read_ins;
  logic             flush;
  logic             clear_flags;
  logic [WIDTH-1:0] data_bus_out;
  logic             data_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CNT_W-1:0] counter_elem;
  logic             overflow;
  logic             underflow;

  modport master (
    output data_bus_in, write_ins, read_ins, flush, clear_flags,
    input  data_bus_out, data_valid, full, empty, almost_full, almost_empty,
           counter_elem, overflow, underflow
  );

  modport slave (
    input  data_bus_in, write_ins, read_ins, flush, clear_flags,
    output data_bus_out, data_valid, full, empty, almost_full, almost_empty,
           counter_elem, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller with storage, show-ahead or registered output,
// programmable almost-full/almost-empty levels, synchronous flush and sticky
// overflow/underflow flags.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sync_fifo_ctrl_if slave modport (data in/out, requests, status)
module sync_fifo_ctrl #(
  parameter int DEPTH        = 32,
  parameter int WIDTH        = 8,
  parameter bit FWFT         = 1'b1,
  parameter int AFULL_LEVEL  = DEPTH - 4,
  parameter int AEMPTY_LEVEL = 4
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LastPtr  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DepthCnt = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, underflow_q;
  logic             full, empty;
  logic             rd_acc, wr_acc;
  logic             ovf_set, unf_set;

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);

  // Flush wins over everything in its cycle: no accepts, no error flags.
  assign rd_acc  = bus.read_ins & ~empty & ~bus.flush;
  assign wr_acc  = bus.write_ins & (~full | rd_acc) & ~bus.flush;
  assign ovf_set = bus.write_ins & full & ~rd_acc & ~bus.flush;
  assign unf_set = bus.read_ins & empty & ~bus.flush;

  // Explicit wrap so non-power-of-two depths work.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PTR_W'(1);
    if (rd_acc) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
      // Set beats clear when both happen together.
      overflow_q  <= ovf_set | (overflow_q & ~bus.clear_flags);
      underflow_q <= unf_set | (underflow_q & ~bus.clear_flags);
    end
  end

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= bus.data_bus_in;
  end

  generate
    if (FWFT) begin : g_show_ahead
      assign bus.data_bus_out = mem[rd_ptr_q];
      assign bus.data_valid   = ~empty;
    end else begin : g_registered
      logic [WIDTH-1:0] dout_q;
      logic             valid_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
          if (rd_acc) dout_q <= mem[rd_ptr_q];
        end
      end
      assign bus.data_bus_out = dout_q;
      assign bus.data_valid   = valid_q;
    end
  endgenerate

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (int'(count_q) >= AFULL_LEVEL);
  assign bus.almost_empty = (int'(count_q) <= AEMPTY_LEVEL);
  assign bus.counter_elem = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl: one show-ahead instance and one registered-output
// instance with different almost levels, driven by the same stimulus and
// compared every cycle against a queue-based model, plus directed literals.
module tb_sync_fifo_ctrl;
  localparam int D   = 5;
  localparam int W   = 8;
  localparam int AF1 = D - 4;
  localparam int AE1 = 4;
  localparam int AF0 = 3;
  localparam int AE0 = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] din;
  logic         wr, rd, fl, cf;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_ctrl_if #(.DEPTH(D), .WIDTH(W)) if1 ();
  sync_fifo_ctrl_if #(.DEPTH(D), .WIDTH(W)) if0 ();

  assign if1.data_bus_in = din;
  assign if1.write_ins   = wr;
  assign if1.read_ins    = rd;
  assign if1.flush       = fl;
  assign if1.clear_flags = cf;
  assign if0.data_bus_in = din;
  assign if0.write_ins   = wr;
  assign if0.read_ins    = rd;
  assign if0.flush       = fl;
  assign if0.clear_flags = cf;

  sync_fifo_ctrl #(.DEPTH(D), .WIDTH(W), .FWFT(1'b1)) u_fwft (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  sync_fifo_ctrl #(.DEPTH(D), .WIDTH(W), .FWFT(1'b0), .AFULL_LEVEL(AF0),
                   .AEMPTY_LEVEL(AE0)) u_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain queue plus flags.
  logic [W-1:0] q[$];
  bit           m_ov, m_un, m_valid;
  logic [W-1:0] m_dout;

  always @(posedge clk or negedge rst_n) begin : model
    bit r, w, os, us;
    if (!rst_n) begin
      q.delete();
      m_ov = 0; m_un = 0; m_valid = 0; m_dout = '0;
    end else if (fl) begin
      q.delete();
      m_valid = 0;
      m_ov = m_ov && !cf;
      m_un = m_un && !cf;
    end else begin
      r  = rd && (q.size() > 0);
      w  = wr && ((q.size() < D) || r);
      os = wr && (q.size() == D) && !r;
      us = rd && (q.size() == 0);
      m_ov = os || (m_ov && !cf);
      m_un = us || (m_un && !cf);
      m_valid = r;
      if (r) m_dout = q.pop_front();
      if (w) q.push_back(din);
    end
  end

  always @(negedge clk) begin : compare
    int n;
    if (chk_en) begin
      n = q.size();
      chk("cnt1",   32'(if1.counter_elem), 32'(n));
      chk("full1",  32'(if1.full),         32'(n == D));
      chk("empty1", 32'(if1.empty),        32'(n == 0));
      chk("af1",    32'(if1.almost_full),  32'(n >= AF1));
      chk("ae1",    32'(if1.almost_empty), 32'(n <= AE1));
      chk("ov1",    32'(if1.overflow),     32'(m_ov));
      chk("un1",    32'(if1.underflow),    32'(m_un));
      chk("dv1",    32'(if1.data_valid),   32'(n != 0));
      if (n != 0) chk("dout1", 32'(if1.data_bus_out), 32'(q[0]));
      chk("cnt0",   32'(if0.counter_elem), 32'(n));
      chk("full0",  32'(if0.full),         32'(n == D));
      chk("empty0", 32'(if0.empty),        32'(n == 0));
      chk("af0",    32'(if0.almost_full),  32'(n >= AF0));
      chk("ae0",    32'(if0.almost_empty), 32'(n <= AE0));
      chk("ov0",    32'(if0.overflow),     32'(m_ov));
      chk("un0",    32'(if0.underflow),    32'(m_un));
      chk("dv0",    32'(if0.data_valid),   32'(m_valid));
      chk("dout0",  32'(if0.data_bus_out), 32'(m_dout));
    end
  end

  task automatic step(input logic w, input logic r, input logic [W-1:0] d,
                      input logic f, input logic c);
    wr = w; rd = r; din = d; fl = f; cf = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [W-1:0] exp3 [5];

  initial begin
    rst_n = 1'b0; wr = 0; rd = 0; din = '0; fl = 0; cf = 0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_empty", 32'(if1.empty), 32'd1);
    chk("rst_ae",    32'(if1.almost_empty), 32'd1);
    chk("rst_dv0",   32'(if0.data_valid), 32'd0);
    rst_n = 1'b1;

    // Fill to full, then overflow attempt.
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h11 + i), 0, 0);
    chk("t1_full", 32'(if1.full), 32'd1);
    chk("t1_cnt",  32'(if1.counter_elem), 32'd5);
    chk("t1_af",   32'(if1.almost_full), 32'd1);
    step(1, 0, 8'h99, 0, 0);
    chk("t1_ov",   32'(if1.overflow), 32'd1);
    step(0, 0, 8'h00, 0, 1);
    chk("t1_clr",  32'(if1.overflow), 32'd0);

    // Full with read+write together.
    for (int i = 0; i < 3; i++) step(1, 1, 8'(8'h21 + i), 0, 0);
    chk("t3_cnt", 32'(if1.counter_elem), 32'd5);
    chk("t3_ov",  32'(if1.overflow), 32'd0);
    exp3[0] = 8'h14; exp3[1] = 8'h15; exp3[2] = 8'h21; exp3[3] = 8'h22; exp3[4] = 8'h23;
    for (int i = 0; i < 5; i++) begin
      chk("t3_head", 32'(if1.data_bus_out), 32'(exp3[i]));
      step(0, 1, 8'h00, 0, 0);
      chk("t3_rd0", 32'(if0.data_bus_out), 32'(exp3[i]));
    end
    chk("t3_empty", 32'(if1.empty), 32'd1);

    // Show-ahead first word, then interleaved traffic across the wrap.
    step(1, 0, 8'hA5, 0, 0);
    chk("t2_head",  32'(if1.data_bus_out), 32'hA5);
    chk("t2_empty", 32'(if1.empty), 32'd0);
    for (int i = 0; i < 7; i++) begin
      step(1, 1, 8'(8'h30 + i), 0, 0);
      chk("t2_rd0", 32'(if0.data_bus_out), (i == 0) ? 32'hA5 : 32'(8'h30 + i - 1));
    end
    chk("t2_cnt", 32'(if1.counter_elem), 32'd1);
    chk("t2_ov",  32'(if1.overflow), 32'd0);
    chk("t2_un",  32'(if1.underflow), 32'd0);
    step(0, 1, 8'h00, 0, 0);

    // Underflow and simultaneous read/write on empty.
    step(0, 1, 8'h00, 0, 0);
    chk("t4_un",  32'(if1.underflow), 32'd1);
    chk("t4_cnt", 32'(if1.counter_elem), 32'd0);
    step(1, 1, 8'h3C, 0, 0);
    chk("t4_cnt1", 32'(if1.counter_elem), 32'd1);
    chk("t4_head", 32'(if1.data_bus_out), 32'h3C);
    step(0, 0, 8'h00, 0, 1);
    chk("t4_clr", 32'(if1.underflow), 32'd0);
    step(0, 1, 8'h00, 0, 0);

    // Registered output mode timing.
    step(1, 0, 8'h01, 0, 0);
    step(1, 0, 8'h02, 0, 0);
    step(0, 1, 8'h00, 0, 0);
    chk("t5_dv_a", 32'(if0.data_valid), 32'd1);
    chk("t5_d_a",  32'(if0.data_bus_out), 32'h01);
    step(0, 1, 8'h00, 0, 0);
    chk("t5_dv_b", 32'(if0.data_valid), 32'd1);
    chk("t5_d_b",  32'(if0.data_bus_out), 32'h02);
    step(0, 0, 8'h00, 0, 0);
    chk("t5_dv_c", 32'(if0.data_valid), 32'd0);
    chk("t5_hold", 32'(if0.data_bus_out), 32'h02);

    // Flush together with a write.
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h50 + i), 0, 0);
    step(1, 0, 8'h77, 1, 0);
    chk("t6_cnt",   32'(if1.counter_elem), 32'd0);
    chk("t6_empty", 32'(if1.empty), 32'd1);
    chk("t6_ov",    32'(if1.overflow), 32'd0);
    chk("t6_un",    32'(if1.underflow), 32'd0);

    // Asynchronous reset mid-burst.
    step(1, 0, 8'h61, 0, 0);
    step(1, 0, 8'h62, 0, 0);
    wr = 1; din = 8'h63;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cnt",   32'(if1.counter_elem), 32'd0);
    chk("ar_empty", 32'(if1.empty), 32'd1);
    chk("ar_full",  32'(if1.full), 32'd0);
    chk("ar_af",    32'(if1.almost_full), 32'd0);
    chk("ar_ae",    32'(if1.almost_empty), 32'd1);
    chk("ar_dv0",   32'(if0.data_valid), 32'd0);
    chk("ar_d0",    32'(if0.data_bus_out), 32'd0);
    wr = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic in phases biased toward filling or draining.
    for (int seg = 0; seg < 6; seg++) begin
      for (int k = 0; k < 400; k++) begin
        step(($urandom_range(0, 99) < ((seg % 2 == 1) ? 80 : 30)),
             ($urandom_range(0, 99) < 50),
             8'($urandom),
             ($urandom_range(0, 99) < 2),
             ($urandom_range(0, 99) < 5));
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Single-clock, synchronous successor to the team's strobe-clocked FIFO.
- Generalised to any DEPTH ≥ 2; no power-of-2 requirement and no limit workaround.
- Adds simultaneous read/write, a selectable output mode (show-ahead or registered), programmable almost-full/almost-empty levels, synchronous flush, and sticky overflow/underflow error flags.
- Sits between the UART/RF byte paths and their consumers as the standard buffering block.

Parameters:
- DEPTH, 32, number of storage entries; any integer ≥ 2.
- WIDTH, 8, data word width in bits.
- FWFT, 1, output mode. 1 = show-ahead: head word is visible on data_bus_out while not empty. 0 = registered: data appears one cycle after an accepted read.
- AFULL_LEVEL, DEPTH-4, almost_full asserts when counter_elem ≥ AFULL_LEVEL; legal range 1..DEPTH.
- AEMPTY_LEVEL, 4, almost_empty asserts when counter_elem ≤ AEMPTY_LEVEL; legal range 0..DEPTH-1.
- Local: CNT_W = $clog2(DEPTH+1); PTR_W = $clog2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_bus_in  in  WIDTH  write data.
- write_ins  in  1  write request, sampled each clock.
- read_ins  in  1  read request, sampled each clock.
- flush  in  1  synchronous clear of contents.
- clear_flags  in  1  synchronous clear of the sticky error flags.
- data_bus_out  out  WIDTH  read data.
- data_valid  out  1  FWFT=1: equals !empty. FWFT=0: one-cycle pulse marking data_bus_out valid.
- full  out  1  counter_elem == DEPTH.
- empty  out  1  counter_elem == 0.
- almost_full  out  1  counter_elem ≥ AFULL_LEVEL.
- almost_empty  out  1  counter_elem ≤ AEMPTY_LEVEL.
- counter_elem  out  CNT_W  number of stored words.
- overflow  out  1  sticky: a write was attempted while full and no read was accepted.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (async, rst_n=0): pointers and count = 0; full=0, empty=1, almost_full=0, almost_empty=1.
- Reset also clears overflow, underflow, data_valid and the output register (FWFT=0) to 0. Memory contents are not reset.
- Accept rules, evaluated on the pre-edge state:
  - rd_acc = read_ins & !empty.
  - wr_acc = write_ins & (!full | rd_acc).
- Both accepted in the same cycle: count unchanged, both pointers advance.
- Full with read and write together: both accepted, no overflow.
- Empty with read and write together: only the write is accepted, and underflow sets.
- Pointers wrap from DEPTH-1 to 0 by explicit compare; no reliance on binary overflow.
- Count arithmetic: count += wr_acc - rd_acc. It never exceeds DEPTH and never goes below 0.
- Status flags are decoded from the registered count, so they update in the cycle after the edge that changes count.
- FWFT=1 output: data_bus_out = mem[rd_ptr], combinational from the registered pointer.
  - The first written word is visible one cycle after the write edge.
  - data_bus_out is don't-care while empty.
- FWFT=0 output: on rd_acc, mem[rd_ptr] is loaded into the output register and data_valid=1 on the next cycle; otherwise data_valid=0.
  - The output register holds its last value when no read is accepted.
- flush=1 at an edge: pointers and count = 0, data_valid = 0. Flush has priority over write/read in that cycle; there are no accepts and no error flags.
- Error flags:
  - overflow sets when write_ins & full & !rd_acc.
  - underflow sets when read_ins & empty.
  - Both are cleared only by clear_flags or reset. If set and clear occur in the same cycle, set wins.
- Reset asserted mid-transfer: the state is abandoned immediately and all outputs return to reset values asynchronously.
- Write to a full FIFO without a read: no storage change and no pointer change.

Test Plan:
1. DEPTH=5, reset then write 0x11..0x15 on 5 consecutive cycles → full=1, counter_elem=5, almost_full=1 (AFULL_LEVEL=1). A 6th write of 0x99 → overflow=1, contents unchanged.
2. DEPTH=5, FWFT=1: write 0xA5 → data_bus_out=0xA5 and empty=0 the next cycle. Then 7 writes interleaved with 7 reads → order preserved across the 4→0 pointer wrap, no flags set.
3. Full FIFO (5 words) with read_ins and write_ins held 3 cycles with data 0x21..0x23 → counter_elem stays 5, no overflow. Subsequent reads return 0x14, 0x15, 0x21, 0x22, 0x23.
4. Empty FIFO: read_ins=1 → underflow=1, counter_elem=0. Same cycle write 0x3C → count=1. clear_flags → underflow=0.
5. FWFT=0: write 0x01, 0x02, then read twice → data_valid pulses on cycles N+1 and N+2 with data 0x01 then 0x02. data_bus_out holds 0x02 afterwards.
6. 3 words stored; assert flush together with a write → count=0, empty=1, no error flags. Separately, drop rst_n mid-burst → outputs return to reset values before the next clk edge.
